// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared types and constants for the instruction-memory loader.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    localparam logic [31:0] c_HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam int          c_BYTE_IDX_W        = 2;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_DONE  = 2'd1,
        ST_ERROR = 2'd2
`ifdef LOADER_CHECKSUM_EN
        ,
        ST_CHECK = 2'd3
`endif
    } loaderState_t;

endpackage
`default_nettype wire

// File: rtl/byte_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : byte_word_assembler
// Description : Packs an MSB-first byte stream into 32-bit words; word_valid
//               strobes alongside the 4th byte, word is the completed value.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_word_assembler
    import loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [23:0]             r_shift;
    logic [c_BYTE_IDX_W-1:0] r_byteIdx;
    logic                    w_take;

    assign w_take     = enable && rx_valid;
    assign word_valid = w_take && (&r_byteIdx);
    // Only three bytes are held; the fourth is appended on the fly.
    assign word       = {r_shift, rx_data};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift   <= '0;
            r_byteIdx <= '0;
        end else if (clear) begin
            r_shift   <= '0;
            r_byteIdx <= '0;
        end else if (w_take) begin
            r_shift   <= {r_shift[15:0], rx_data};
            r_byteIdx <= r_byteIdx + c_BYTE_IDX_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_program_loader
// Description : Fills instruction memory from a byte stream and holds the core
//               in reset until the program ends. Optional trailing checksum
//               byte enabled by defining LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_program_loader
    import loader_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] HALT_WORD  = c_HALT_WORD_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  load_req,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  full,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam logic [ADDR_WIDTH:0] c_LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};

    loaderState_t r_state;
    logic         r_pendHalt;
    logic         r_pendFull;
    logic         w_asmEnable;
    logic         w_accept;
    logic         w_restart;
    logic         w_wordValid;
    logic [31:0]  w_word;

    // Once the final word is committed, further bytes belong to no word.
    assign w_asmEnable = (r_state == ST_LOAD) && !r_pendHalt && !r_pendFull;
    assign w_accept    = w_asmEnable && rx_valid;
    assign w_restart   = load_req && ((r_state == ST_DONE) || (r_state == ST_ERROR));

    byte_word_assembler u_assembler (
        .clock      (clock),
        .reset      (reset),
        .clear      (w_restart),
        .enable     (w_asmEnable),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .word_valid (w_wordValid),
        .word       (w_word)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_xor;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_xor <= '0;
        end else if (w_restart) begin
            r_xor <= '0;
        end else if (w_accept) begin
            r_xor <= r_xor ^ rx_data;
        end
    end
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_LOAD;
            r_pendHalt <= 1'b0;
            r_pendFull <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            full       <= 1'b0;
            word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
            error      <= 1'b0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    if (r_pendHalt) begin
                        r_pendHalt <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        // A checksum byte landing on the halt write cycle is used directly.
                        if (rx_valid) begin
                            busy <= 1'b0;
                            if (rx_data == r_xor) begin
                                r_state   <= ST_DONE;
                                cpu_reset <= 1'b0;
                                done      <= 1'b1;
                            end else begin
                                r_state <= ST_ERROR;
                                error   <= 1'b1;
                            end
                        end else begin
                            r_state <= ST_CHECK;
                        end
`else
                        r_state   <= ST_DONE;
                        cpu_reset <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
`endif
                    end else if (r_pendFull) begin
                        r_pendFull <= 1'b0;
                        r_state    <= ST_DONE;
                        full       <= 1'b1;
                        cpu_reset  <= 1'b0;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                    end else if (w_wordValid) begin
                        imem_we    <= 1'b1;
                        imem_wdata <= w_word;
                        imem_addr  <= word_count[ADDR_WIDTH-1:0];
                        word_count <= word_count + (ADDR_WIDTH+1)'(1);
                        if (w_word == HALT_WORD) begin
                            r_pendHalt <= 1'b1;
                        end else if (word_count == c_LAST_ADDR) begin
                            r_pendFull <= 1'b1;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (rx_valid) begin
                        busy <= 1'b0;
                        if (rx_data == r_xor) begin
                            r_state   <= ST_DONE;
                            cpu_reset <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            r_state <= ST_ERROR;
                            error   <= 1'b1;
                        end
                    end
                end
`endif
                ST_DONE, ST_ERROR: begin
                    if (load_req) begin
                        r_state    <= ST_LOAD;
                        word_count <= '0;
                        full       <= 1'b0;
                        cpu_reset  <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        error      <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_program_loader
// Description : Scoreboard bench for imem_program_loader (directed vectors).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_program_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        load_req = 1'b0;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        full;
    logic        error;
    logic [8:0]  word_count;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t expQ[$];
    int  nChecks = 0;
    int  nPass   = 0;

    imem_program_loader dut (
        .clock      (clock),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .load_req   (load_req),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .full       (full),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clock) begin
        if (!reset && imem_we) begin
            if (expQ.size() == 0) begin
                nChecks++;
                $display("FAIL unexpectedWrite: got addr %0h data %0h expected no write", imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                check("wrAddr", 64'(imem_addr), 64'(e.addr));
                check("wrData", 64'(imem_wdata), 64'(e.data));
            end
        end
    end

    task automatic sendByte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic sendWord(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) sendByte(w[8*k +: 8]);
    endtask

    task automatic expectWr(input logic [7:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        expQ.push_back(e);
    endtask

    task automatic pulseLoadReq();
        rx_valid = 1'b0;
        load_req = 1'b1;
        @(posedge clock);
        #1;
        load_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, sampled while reset is held.
        repeat (2) @(posedge clock);
        #1;
        check("rstWe",        64'(imem_we),    64'd0);
        check("rstAddr",      64'(imem_addr),  64'd0);
        check("rstWdata",     64'(imem_wdata), 64'd0);
        check("rstCpuReset",  64'(cpu_reset),  64'd1);
        check("rstBusy",      64'(busy),       64'd1);
        check("rstDone",      64'(done),       64'd0);
        check("rstFull",      64'(full),       64'd0);
        check("rstError",     64'(error),      64'd0);
        check("rstWordCount", 64'(word_count), 64'd0);
        reset = 1'b0;
        idle(1);

        // Basic program: two words back to back, second is the halt marker.
        expectWr(8'h00, 32'h2008_0005);
        expectWr(8'h01, 32'hFFFF_FFFF);
        sendByte(8'h20); sendByte(8'h08); sendByte(8'h00); sendByte(8'h05);
        check("weLatency",   64'(imem_we),    64'd1);
        check("wcOnWrite",   64'(word_count), 64'd1);
        check("busyInLoad",  64'(busy),       64'd1);
        sendWord(32'hFFFF_FFFF);
`ifdef LOADER_CHECKSUM_EN
        idle(1);
        sendByte(8'h2D);
`endif
        idle(2);
        check("haltDone",     64'(done),       64'd1);
        check("haltCpuReset", 64'(cpu_reset),  64'd0);
        check("haltBusy",     64'(busy),       64'd0);
        check("haltWc",       64'(word_count), 64'd2);
        check("haltFull",     64'(full),       64'd0);

        // Bytes in DONE are ignored, then restart.
        sendWord(32'h1122_3344);
        idle(2);
        check("doneIgnoreWc", 64'(word_count), 64'd2);
        check("doneStays",    64'(done),       64'd1);
        pulseLoadReq();
        check("restartBusy",     64'(busy),       64'd1);
        check("restartCpuReset", 64'(cpu_reset),  64'd1);
        check("restartDone",     64'(done),       64'd0);
        check("restartWc",       64'(word_count), 64'd0);
        expectWr(8'h00, 32'hAABB_CCDD);
        sendWord(32'hAABB_CCDD);
        idle(2);

        // Reset mid-word: partial bytes are discarded.
        sendByte(8'h20); idle(1); sendByte(8'h08); idle(1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("midRstWc",   64'(word_count), 64'd0);
        check("midRstBusy", 64'(busy),       64'd1);
        expectWr(8'h00, 32'h0000_0001);
        sendByte(8'h00); idle(1); sendByte(8'h00); idle(1);
        sendByte(8'h00); idle(1); sendByte(8'h01); idle(2);
        check("midRstWc2", 64'(word_count), 64'd1);

        // Fill all 256 locations without a halt word.
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            logic [31:0] w;
            w = {i[7:0], 8'h5A, 8'hC3, i[7:0]};
            expectWr(i[7:0], w);
            sendWord(w);
        end
        sendWord(32'h0102_0304);
        idle(2);
        check("fullFlag",     64'(full),       64'd1);
        check("fullDone",     64'(done),       64'd1);
        check("fullWc",       64'(word_count), 64'h100);
        check("fullCpuReset", 64'(cpu_reset),  64'd0);

`ifdef LOADER_CHECKSUM_EN
        pulseLoadReq();
        check("ckRestartFull", 64'(full), 64'd0);
        expectWr(8'h00, 32'h0102_0304);
        expectWr(8'h01, 32'hFFFF_FFFF);
        sendWord(32'h0102_0304);
        sendWord(32'hFFFF_FFFF);
        idle(1);
        sendByte(8'h04);
        idle(2);
        check("ckGoodDone",  64'(done),  64'd1);
        check("ckGoodError", 64'(error), 64'd0);
        pulseLoadReq();
        expectWr(8'h00, 32'h0102_0304);
        expectWr(8'h01, 32'hFFFF_FFFF);
        sendWord(32'h0102_0304);
        sendWord(32'hFFFF_FFFF);
        idle(1);
        sendByte(8'h05);
        idle(2);
        check("ckBadError",    64'(error),     64'd1);
        check("ckBadCpuReset", 64'(cpu_reset), 64'd1);
        check("ckBadDone",     64'(done),      64'd0);
`else
        check("errorTiedLow", 64'(error), 64'd0);
`endif

        idle(2);
        check("queueDrained", 64'(expQ.size()), 64'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
